lx32_store_buffer: RTL
======================

// Module: lx32_store_buffer
// PURPOSE
//   Posted-write buffer directly downstream of the LX32 single-cycle core's data
//   memory port. Core stores retire in one cycle into a FIFO; the FIFO drains to the
//   data bus over a valid/ready handshake. Loads forward from the youngest matching
//   pending store, otherwise pass through to the memory read port.
// PARAMETERS
//   DEPTH   4  store entries; power of two, >= 2
//   FWD_EN  1  1: store-to-load forwarding enabled; 0: loads always read rd_data
// PORTS
//   clk         in   1   single clock, all state on posedge
//   rst         in   1   asynchronous, active-low reset (0 = reset)
//   core_addr   in   32  byte address from core LSU
//   core_wdata  in   32  store data from core LSU
//   core_we     in   1   store request this cycle
//   core_rdata  out  32  load data to core write-back (combinational)
//   stall       out  1   buffer full; core must not store this cycle
//   rd_addr     out  32  memory read address (= core_addr, combinational)
//   rd_data     in   32  memory read data (asynchronous read port)
//   bus_valid   out  1   head entry presented to memory
//   bus_ready   in   1   memory accepts head entry
//   bus_addr    out  32  head entry address
//   bus_wdata   out  32  head entry data
//   count       out  $clog2(DEPTH+1)  occupied entries
//   overflow    out  1   sticky: store dropped while full
// BEHAVIOUR
//   - Reset (rst==0, async): wr_ptr=rd_ptr=0, count=0, bus_valid=0, overflow=0,
//     stall=0. Entry contents are don't-care. Pending stores are discarded, and
//     bus_valid drops without waiting for a clock edge.
//   - push = core_we && (count<DEPTH || pop). pop = bus_valid && bus_ready.
//   - Push writes {core_addr, core_wdata} at wr_ptr and wr_ptr++ (mod DEPTH).
//     Pop does rd_ptr++ (mod DEPTH). Pointers are $clog2(DEPTH) bits and wrap naturally.
//   - count_next = count + push - pop. Simultaneous push and pop while full is legal:
//     count stays DEPTH.
//   - Push while full with no pop: the store is dropped, state is unchanged, and
//     overflow is set to 1. Only reset clears overflow.
//   - stall = (count==DEPTH), combinational from registered count.
//   - bus_valid = (count!=0). bus_addr and bus_wdata = entry[rd_ptr]. Both are stable
//     while bus_valid=1 and !bus_ready (AXI-style: valid never retracted before
//     handshake, except by reset).
//   - Store latency: core_we at edge N -> bus_valid=1 after edge N at the earliest
//     (one cycle). Back-to-back pops are allowed every cycle.
//   - rd_addr = core_addr always.
//   - Forwarding (FWD_EN=1):
//     - Compare core_addr[31:2] against each occupied entry's addr[31:2].
//     - The youngest match (closest behind wr_ptr) drives core_rdata.
//     - No match: core_rdata = rd_data.
//     - Only full-word stores exist; no byte merging.
//   - The entry being popped in the current cycle still counts as occupied for
//     forwarding in that cycle.
//   - A store in the current cycle is not forwarded to itself. Forwarding uses
//     registered contents only.
//   - FWD_EN=0: core_rdata = rd_data unconditionally.
//     Note: loads may then see stale memory.
// TESTING
//   1. Reset, then store A=0x100/0x11 with bus_ready=1 -> bus_valid=1 the next
//      cycle with bus_addr=0x100 and bus_wdata=0x11. count 1->0 after the handshake.
//   2. bus_ready=0; store 0x100..0x10C (4 stores) -> count=4, stall=1. A fifth
//      store -> dropped, overflow=1, count stays 4. Then bus_ready=1 -> drains in
//      order 0x100,0x104,0x108,0x10C over 4 cycles.
//   3. Full, with core_we and bus_ready in the same cycle -> count stays 4. New
//      entry is last out, and the pointers wrap correctly.
//   4. Pending stores 0x200=0xAA, then 0x200=0xBB; load 0x202 with rd_data=0x55 ->
//      core_rdata=0xBB. Load 0x300 -> core_rdata=0x55.
//   5. bus_ready held 0 for 5 cycles -> bus_addr and bus_wdata unchanged every cycle.
//   6. 2 entries pending; rst=0 between edges -> bus_valid=0 and count=0
//      immediately. After release, no stale writes appear on the bus.

Source files
------------

// File: rtl/lx32_store_buffer.sv
// Posted-write store buffer between the LX32 core data port and the data bus.
// Latency: a store is presented on the bus one cycle after it is accepted; loads resolve combinationally.
// Backpressure: stall while full; a store issued while full with no drain is dropped and sets overflow.
//
// Ports:
//   clk, rst                         clock, async active-low reset
//   core_addr/core_wdata/core_we     store/load request from the core LSU
//   core_rdata                       load data (forwarded or rd_data)
//   stall                            buffer full
//   rd_addr/rd_data                  memory asynchronous read port
//   bus_valid/bus_ready              head-entry drain handshake
//   bus_addr/bus_wdata               head entry contents
//   count, overflow                  occupancy and sticky drop flag
module lx32_store_buffer #(
  parameter int DEPTH  = 4,
  parameter bit FWD_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                core_addr,
  input  logic [31:0]                core_wdata,
  input  logic                       core_we,
  output logic [31:0]                core_rdata,
  output logic                       stall,
  output logic [31:0]                rd_addr,
  input  logic [31:0]                rd_data,
  output logic                       bus_valid,
  input  logic                       bus_ready,
  output logic [31:0]                bus_addr,
  output logic [31:0]                bus_wdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   ent_addr [DEPTH];
  logic [31:0]   ent_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [31:0]   fwd_data;
  logic [PW-1:0] idx;

  assign stall     = (count == FULL);
  assign bus_valid = (count != '0);
  assign bus_addr  = ent_addr[rd_ptr];
  assign bus_wdata = ent_data[rd_ptr];
  assign rd_addr   = core_addr;

  assign pop  = bus_valid && bus_ready;
  // A drain in the same cycle frees the slot, so a store while full is still accepted.
  assign push = core_we && (!stall || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (core_we && stall && !pop) overflow <= 1'b1;
    end
  end

  // Entry storage carries no reset; contents are only observed while occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= core_addr;
      ent_data[wr_ptr] <= core_wdata;
    end
  end

  // Walk occupied entries oldest to youngest; later matches override earlier
  // ones so the youngest matching store wins. Only registered entries are
  // searched, so a same-cycle store never forwards to itself.
  always_comb begin
    fwd_data = rd_data;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (ent_addr[idx][31:2] == core_addr[31:2]))
        fwd_data = ent_data[idx];
    end
  end

  assign core_rdata = FWD_EN ? fwd_data : rd_data;

endmodule
